// File: rtl/prbs_pkg.sv
// Shared definitions for the PRBS7 generator/checker slice.
package prbs_pkg;

  // x^7 + x^6 + 1: s[n] = s[n-7] ^ s[n-6]
  localparam int PRBS7_TAP_A = 7;
  localparam int PRBS7_TAP_B = 6;
  localparam int FRAME_W     = 64;
  // Wide enough to hold a violation count of 0..FRAME_W
  localparam int NERR_W      = $clog2(FRAME_W + 1);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } prbs_state_e;

endpackage

// File: rtl/prbs_if.sv
// Frame bus between a PRBS source (or receive path) and the checker.
//
// Handshake: frame_valid qualifies frame_in and is sampled on every rising
// clk edge. There is no ready/backpressure: the checker consumes every
// valid frame in the cycle it is presented. clear_cnt is an independent
// level-sampled command. All status outputs are registered.
interface prbs_if
  import prbs_pkg::*;
#(
  parameter int CNT_W = 32
);

  logic               frame_valid;
  logic [FRAME_W-1:0] frame_in;
  logic               clear_cnt;
  logic               locked;
  logic               frame_err;
  logic [NERR_W-1:0]  frame_err_bits;
  logic [CNT_W-1:0]   err_cnt;
  logic [CNT_W-1:0]   frame_cnt;

  modport master (
    output frame_valid, frame_in, clear_cnt,
    input  locked, frame_err, frame_err_bits, err_cnt, frame_cnt
  );

  modport slave (
    input  frame_valid, frame_in, clear_cnt,
    output locked, frame_err, frame_err_bits, err_cnt, frame_cnt
  );

endinterface

// File: rtl/prbs_popcount.sv
// Combinational population count of a 64-bit vector as a balanced adder
// tree; each level is only as wide as its partial sums need to be.
module prbs_popcount
  import prbs_pkg::*;
(
  input  logic [FRAME_W-1:0] bits_in,
  output logic [NERR_W-1:0]  count
);

  logic [1:0] l1 [32];
  logic [2:0] l2 [16];
  logic [3:0] l3 [8];
  logic [4:0] l4 [4];
  logic [5:0] l5 [2];

  // Pairwise sums, one tree level per loop
  always_comb begin
    for (int i = 0; i < 32; i++) l1[i] = {1'b0, bits_in[2*i]} + {1'b0, bits_in[2*i+1]};
    for (int i = 0; i < 16; i++) l2[i] = {1'b0, l1[2*i]} + {1'b0, l1[2*i+1]};
    for (int i = 0; i < 8; i++)  l3[i] = {1'b0, l2[2*i]} + {1'b0, l2[2*i+1]};
    for (int i = 0; i < 4; i++)  l4[i] = {1'b0, l3[2*i]} + {1'b0, l3[2*i+1]};
    for (int i = 0; i < 2; i++)  l5[i] = {1'b0, l4[2*i]} + {1'b0, l4[2*i+1]};
    count = {1'b0, l5[0]} + {1'b0, l5[1]};
  end

endmodule

// File: rtl/prbs_checker.sv
// Self-synchronising PRBS7 frame checker: predicts every bit from the
// received history, declares lock/loss-of-lock and counts bit errors.
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int LOCK_FRAMES = 4,
  parameter int UNLOCK_ERR  = 8,
  parameter int CNT_W       = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  prbs_if.slave       bus,
  output prbs_state_e dbg_state
);

  localparam int HIST_W = PRBS7_TAP_A;
  localparam int RUN_W  = $clog2(LOCK_FRAMES + 1);
  localparam logic [RUN_W-1:0]  LOCK_TGT   = RUN_W'(LOCK_FRAMES);
  localparam logic [NERR_W-1:0] UNLOCK_LIM = NERR_W'(UNLOCK_ERR);

  prbs_state_e                 state, state_nxt;
  logic [RUN_W-1:0]            clean_run, clean_run_nxt;
  logic [HIST_W-1:0]           hist;
  logic                        hist_valid;
  logic [FRAME_W+HIST_W-1:0]   ext;
  logic [FRAME_W-1:0]          viol;
  logic [NERR_W-1:0]           nerr;
  logic                        frame_zero;
  logic                        frame_clean;
  logic                        unlock_hit;
  logic [CNT_W-1:0]            err_base, frm_base;
  logic [CNT_W:0]              err_sum, frm_sum;
  logic [CNT_W-1:0]            err_sat, frm_sat;
  logic [CNT_W-1:0]            err_cnt_q, frame_cnt_q;
  logic                        frame_err_q;
  logic [NERR_W-1:0]           frame_err_bits_q;

  // Stream view: ext[k] is s[k-HIST_W] relative to this frame's bit 0
  assign ext = {bus.frame_in, hist};

  // Violation vector; the first HIST_W bits are unpredictable without history
  always_comb begin
    viol = '0;
    for (int n = 0; n < FRAME_W; n++) begin
      viol[n] = bus.frame_in[n] ^ ext[n + HIST_W - PRBS7_TAP_A]
                                ^ ext[n + HIST_W - PRBS7_TAP_B];
    end
    if (!hist_valid) viol[HIST_W-1:0] = '0;
  end

  prbs_popcount u_popcount (
    .bits_in (viol),
    .count   (nerr)
  );

  // All-zero frames satisfy the recurrence, so they are treated as a stuck link
  assign frame_zero  = (bus.frame_in == '0);
  assign frame_clean = (nerr == '0) && hist_valid && !frame_zero;
  assign unlock_hit  = (nerr > UNLOCK_LIM) || frame_zero;

  // Next-state logic for HUNT/LOCKED and the clean-frame run counter
  always_comb begin
    state_nxt     = state;
    clean_run_nxt = clean_run;
    if (bus.frame_valid) begin
      case (state)
        HUNT: begin
          if (frame_clean) begin
            if (clean_run == LOCK_TGT - 1'b1) begin
              state_nxt     = LOCKED;
              clean_run_nxt = '0;
            end else begin
              clean_run_nxt = clean_run + 1'b1;
            end
          end else begin
            clean_run_nxt = '0;
          end
        end
        LOCKED: begin
          clean_run_nxt = '0;
          if (unlock_hit) state_nxt = HUNT;
        end
        default: begin
          state_nxt     = HUNT;
          clean_run_nxt = '0;
        end
      endcase
    end
  end

  // State register and clean-run counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= HUNT;
      clean_run <= '0;
    end else begin
      state     <= state_nxt;
      clean_run <= clean_run_nxt;
    end
  end

  // History of the last HIST_W received bits; gaps leave it untouched
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist       <= '0;
      hist_valid <= 1'b0;
    end else if (bus.frame_valid) begin
      hist       <= bus.frame_in[FRAME_W-1:FRAME_W-HIST_W];
      hist_valid <= 1'b1;
    end
  end

  // Saturating next values; clear_cnt with a frame means clear-then-add
  always_comb begin
    err_base = bus.clear_cnt ? '0 : err_cnt_q;
    frm_base = bus.clear_cnt ? '0 : frame_cnt_q;
    err_sum  = {1'b0, err_base} + {{(CNT_W + 1 - NERR_W){1'b0}}, nerr};
    frm_sum  = {1'b0, frm_base} + 1'b1;
    err_sat  = err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
    frm_sat  = frm_sum[CNT_W] ? '1 : frm_sum[CNT_W-1:0];
  end

  // Error and frame counters: accumulate only for frames checked while locked
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q   <= '0;
      frame_cnt_q <= '0;
    end else if (bus.frame_valid && state == LOCKED) begin
      err_cnt_q   <= err_sat;
      frame_cnt_q <= frm_sat;
    end else if (bus.clear_cnt) begin
      err_cnt_q   <= '0;
      frame_cnt_q <= '0;
    end
  end

  // Per-frame status: error pulse and held violation count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err_q      <= 1'b0;
      frame_err_bits_q <= '0;
    end else begin
      frame_err_q <= bus.frame_valid && (nerr != '0);
      if (bus.frame_valid) frame_err_bits_q <= nerr;
    end
  end

  assign bus.locked         = (state == LOCKED);
  assign bus.frame_err      = frame_err_q;
  assign bus.frame_err_bits = frame_err_bits_q;
  assign bus.err_cnt        = err_cnt_q;
  assign bus.frame_cnt      = frame_cnt_q;
  assign dbg_state          = state;

endmodule
